hs32_intctl: RTL and testbench

Interrupt controller sitting on the responder side of the hs32 CPU interrupt interface. It collects per-line interrupt events from the CPU's `interrupts` outputs and from external sources, and holds them as pending bits. It arbitrates by fixed priority and presents one request at a time (`intrq`, `vec`, `handler`, `nmi`) until the CPU answers with `iack`. Its handler table, enable mask and pending register are programmed through a memory-mapped responder port, which acts as the target end of the hs32 `stb`/`ack` bus.

---
 rtl/hs32_intctl_pkg.sv | 15 +
 rtl/hs32_intctl_table.sv | 35 +++
 rtl/hs32_intctl.sv | 177 +++++++++++++++++
 tb/tb_hs32_intctl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hs32_intctl_pkg.sv
// Shared encodings for the hs32 interrupt controller: FSM states and bus register indexes.
package hs32_intctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_REQ    = 2'd2
  } ic_state_e;

  localparam logic [4:0] IC_EN   = 5'd24;
  localparam logic [4:0] IC_PEND = 5'd25;
  localparam logic [4:0] IC_STAT = 5'd26;
  localparam logic [4:0] NMI_VEC = 5'd0;

endpackage

// File: rtl/hs32_intctl_table.sv
// Handler address table: one synchronous bus write port, combinational bus and arbiter read ports.
module hs32_intctl_table #(
  parameter int NLINES = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic [4:0]  arb_addr,
  output logic [31:0] arb_data
);

  logic [31:0] mem_q [NLINES];
  logic [31:0] mem_d [NLINES];

  always_comb begin
    mem_d = mem_q;
    if (we && int'(waddr) < NLINES) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NLINES; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata    = (int'(raddr) < NLINES) ? mem_q[raddr] : '0;
  assign arb_data = (int'(arb_addr) < NLINES) ? mem_q[arb_addr] : '0;

endmodule

// File: rtl/hs32_intctl.sv
// hs32 interrupt controller: edge-triggered pending bits, fixed-priority arbitration, bus-programmed table.
// state  | meaning
// IDLE   | waiting for an enabled pending line; latches the winner into cur
// LOOKUP | registers handler/vec/nmi for cur and raises intrq
// REQ    | request held stable until iack clears pend[cur]
module hs32_intctl
  import hs32_intctl_pkg::*;
#(
  parameter int NLINES   = 24,
  parameter int EXT_SYNC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NLINES-1:0] cpu_int,
  input  logic [NLINES-1:0] ext_irq,
  input  logic              nmi_in,
  output logic              intrq,
  output logic [4:0]        vec,
  output logic [31:0]       handler,
  output logic              nmi,
  input  logic              iack,
  input  logic              stb,
  input  logic              rw,
  input  logic [4:0]        addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              ack
);

  logic [NLINES-1:0] ext_sync_q [EXT_SYNC];
  logic [NLINES-1:0] ext_sync_d [EXT_SYNC];
  logic [EXT_SYNC-1:0] nmi_sync_q, nmi_sync_d;
  logic [NLINES-1:0] line_prev_q, line_prev_d;
  logic              nmi_prev_q, nmi_prev_d;
  logic [NLINES-1:0] pend_q, pend_d;
  logic [NLINES-1:0] en_q, en_d;
  ic_state_e         state_q, state_d;
  logic [4:0]        cur_q, cur_d, vec_q, vec_d;
  logic              intrq_q, intrq_d, nmi_q, nmi_d, ack_q, ack_d;
  logic [31:0]       handler_q, handler_d, dout_q, dout_d;

  logic [NLINES-1:0] line_now, set_v, clr_v, iack_clr, cand;
  logic              nmi_rise, bus_wr, tbl_we;
  logic [31:0]       tbl_rdata, arb_data, rdata;

  function automatic logic [4:0] pri_enc(input logic [NLINES-1:0] c);
    logic [4:0] idx;
    idx = '0;
    for (int i = NLINES - 1; i >= 0; i--) if (c[i]) idx = 5'(i);
    return idx;
  endfunction

  assign bus_wr = stb && rw;
  assign tbl_we = bus_wr && int'(addr) < NLINES;

  hs32_intctl_table #(.NLINES(NLINES)) u_table (
    .clk      (clk),
    .reset    (reset),
    .we       (tbl_we),
    .waddr    (addr),
    .wdata    (din),
    .raddr    (addr),
    .rdata    (tbl_rdata),
    .arb_addr (cur_q),
    .arb_data (arb_data)
  );

  always_comb begin
    ext_sync_d[0] = ext_irq;
    for (int i = 1; i < EXT_SYNC; i++) ext_sync_d[i] = ext_sync_q[i-1];
    nmi_sync_d = {nmi_sync_q[EXT_SYNC-2:0], nmi_in};
  end

  assign line_now    = cpu_int | ext_sync_q[EXT_SYNC-1];
  assign line_prev_d = line_now;
  assign nmi_prev_d  = nmi_sync_q[EXT_SYNC-1];
  assign nmi_rise    = nmi_sync_q[EXT_SYNC-1] && !nmi_prev_q;
  assign set_v       = (line_now & ~line_prev_q) | {{(NLINES-1){1'b0}}, nmi_rise};
  assign cand        = pend_q & {en_q[NLINES-1:1], 1'b1};

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    intrq_d   = intrq_q;
    vec_d     = vec_q;
    handler_d = handler_q;
    nmi_d     = nmi_q;
    iack_clr  = '0;
    case (state_q)
      ST_IDLE: begin
        if (|cand) begin
          cur_d   = pri_enc(cand);
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        handler_d = arb_data;
        vec_d     = cur_q;
        nmi_d     = (cur_q == NMI_VEC);
        intrq_d   = 1'b1;
        state_d   = ST_REQ;
      end
      ST_REQ: begin
        if (iack) begin
          iack_clr[cur_q] = 1'b1;
          intrq_d = 1'b0;
          nmi_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Set beats clear on the same bit, whether the clear comes from iack or the bus.
  always_comb begin
    clr_v = iack_clr;
    if (bus_wr && addr == IC_PEND) clr_v = clr_v | din[NLINES-1:0];
    pend_d = (pend_q & ~clr_v) | set_v;
    en_d   = en_q;
    if (bus_wr && addr == IC_EN) en_d = {din[NLINES-1:1], 1'b0};
  end

  always_comb begin
    rdata = '0;
    case (addr)
      IC_EN:   rdata = 32'({en_q[NLINES-1:1], 1'b1});
      IC_PEND: rdata = 32'(pend_q);
      IC_STAT: rdata = {24'b0, state_q, 1'b0, cur_q};
      default: if (int'(addr) < NLINES) rdata = tbl_rdata;
    endcase
    ack_d  = stb;
    dout_d = (stb && !rw) ? rdata : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < EXT_SYNC; i++) ext_sync_q[i] <= '0;
      nmi_sync_q  <= '0;
      line_prev_q <= '0;
      nmi_prev_q  <= 1'b0;
      pend_q      <= '0;
      en_q        <= '0;
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      vec_q       <= '0;
      intrq_q     <= 1'b0;
      nmi_q       <= 1'b0;
      handler_q   <= '0;
      ack_q       <= 1'b0;
      dout_q      <= '0;
    end else begin
      ext_sync_q  <= ext_sync_d;
      nmi_sync_q  <= nmi_sync_d;
      line_prev_q <= line_prev_d;
      nmi_prev_q  <= nmi_prev_d;
      pend_q      <= pend_d;
      en_q        <= en_d;
      state_q     <= state_d;
      cur_q       <= cur_d;
      vec_q       <= vec_d;
      intrq_q     <= intrq_d;
      nmi_q       <= nmi_d;
      handler_q   <= handler_d;
      ack_q       <= ack_d;
      dout_q      <= dout_d;
    end
  end

  assign intrq   = intrq_q;
  assign vec     = vec_q;
  assign handler = handler_q;
  assign nmi     = nmi_q;
  assign ack     = ack_q;
  assign dout    = dout_q;

endmodule

// File: tb/tb_hs32_intctl.sv
// Directed and randomized checks of hs32_intctl against a pending-set/priority model.
module tb_hs32_intctl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] cpu_int = '0, ext_irq = '0;
  logic        nmi_in = 1'b0, iack = 1'b0, stb = 1'b0, rw = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] din = '0;
  logic        intrq, nmi, ack;
  logic [4:0]  vec;
  logic [31:0] handler, dout;

  int checks = 0;
  int failures = 0;

  logic [23:0] pend_m, en_m;
  logic [31:0] tbl_m [24];

  hs32_intctl #(.NLINES(24), .EXT_SYNC(2)) dut (
    .clk(clk), .reset(reset), .cpu_int(cpu_int), .ext_irq(ext_irq), .nmi_in(nmi_in),
    .intrq(intrq), .vec(vec), .handler(handler), .nmi(nmi), .iack(iack),
    .stb(stb), .rw(rw), .addr(addr), .din(din), .dout(dout), .ack(ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    stb = 1'b1; rw = 1'b1; addr = a; din = d;
    tick();
    chk("wr_ack", 32'(ack), 32'd1);
    stb = 1'b0; rw = 1'b0;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    stb = 1'b1; rw = 1'b0; addr = a;
    tick();
    chk("rd_ack", 32'(ack), 32'd1);
    d = dout;
    stb = 1'b0;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 12 && !intrq; k++) tick();
    chk("req_timeout", 32'(intrq), 32'd1);
  endtask

  task automatic do_iack();
    iack = 1'b1;
    tick();
    iack = 1'b0;
    chk("iack_drop", 32'(intrq), 32'd0);
  endtask

  // Serve every enabled pending line in lowest-index-first order.
  task automatic serve();
    int w;
    for (int s = 0; s < 25; s++) begin
      w = -1;
      for (int i = 23; i >= 0; i--) if (pend_m[i] && (i == 0 || en_m[i])) w = i;
      if (w < 0) break;
      wait_req();
      chk("rnd_vec", 32'(vec), 32'(w));
      chk("rnd_handler", handler, tbl_m[w]);
      chk("rnd_nmi", 32'(nmi), 32'd0);
      do_iack();
      pend_m[w] = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [23:0] m;
    int idx;

    #12;
    chk("rst_intrq", 32'(intrq), 32'd0);
    chk("rst_nmi", 32'(nmi), 32'd0);
    chk("rst_vec", 32'(vec), 32'd0);
    chk("rst_handler", handler, 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dout", dout, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();

    // single maskable line with exact latency
    bus_wr(5'd24, 32'h20);
    bus_wr(5'd5, 32'h1234);
    cpu_int[5] = 1'b1;
    tick(); cpu_int = '0;
    chk("lat_n1", 32'(intrq), 32'd0);
    tick();
    chk("lat_n2", 32'(intrq), 32'd0);
    tick();
    chk("lat_n3_intrq", 32'(intrq), 32'd1);
    chk("lat_vec", 32'(vec), 32'd5);
    chk("lat_handler", handler, 32'h1234);
    chk("lat_nmi", 32'(nmi), 32'd0);
    do_iack();
    bus_rd(5'd25, rd);
    chk("lat_pend_clr", rd, 32'd0);

    // priority and masking
    bus_wr(5'd24, 32'h200);
    cpu_int = 24'h208;
    tick(); cpu_int = '0;
    tick(); tick();
    chk("prio_vec9", 32'(vec), 32'd9);
    bus_rd(5'd25, rd);
    chk("prio_pend", rd, 32'h208);
    bus_wr(5'd24, 32'h208);
    chk("prio_hold", 32'(vec), 32'd9);
    do_iack();
    tick();
    chk("b2b_gap", 32'(intrq), 32'd0);
    tick();
    chk("b2b_intrq", 32'(intrq), 32'd1);
    chk("b2b_vec3", 32'(vec), 32'd3);
    do_iack();

    // NMI with synchronizer latency
    bus_wr(5'd24, 32'h0);
    bus_wr(5'd0, 32'hFFFF_0000);
    nmi_in = 1'b1;
    repeat (4) tick();
    chk("nmi_early", 32'(intrq), 32'd0);
    tick();
    chk("nmi_intrq", 32'(intrq), 32'd1);
    chk("nmi_flag", 32'(nmi), 32'd1);
    chk("nmi_vec", 32'(vec), 32'd0);
    chk("nmi_handler", handler, 32'hFFFF_0000);
    do_iack();
    chk("nmi_flag_clr", 32'(nmi), 32'd0);
    nmi_in = 1'b0;
    repeat (3) tick();

    // NMI arriving during a maskable request is served right after it
    bus_wr(5'd24, 32'h10);
    cpu_int[4] = 1'b1;
    tick(); cpu_int = '0;
    tick(); tick();
    chk("nmi4_vec", 32'(vec), 32'd4);
    nmi_in = 1'b1;
    repeat (6) tick();
    chk("nmi4_nopreempt", 32'(vec), 32'd4);
    chk("nmi4_nmi_low", 32'(nmi), 32'd0);
    do_iack();
    tick(); tick();
    chk("nmi4_next_nmi", 32'(nmi), 32'd1);
    chk("nmi4_next_vec", 32'(vec), 32'd0);
    do_iack();
    nmi_in = 1'b0;
    repeat (3) tick();

    // bus accesses
    bus_wr(5'd7, 32'hDEAD_BEEF);
    chk("wr_dout0", dout, 32'd0);
    bus_rd(5'd7, rd);
    chk("rd_tbl7", rd, 32'hDEAD_BEEF);
    tick();
    chk("ack_1cyc", 32'(ack), 32'd0);
    chk("dout_idle", dout, 32'd0);
    bus_rd(5'd30, rd);
    chk("rd_unmapped", rd, 32'd0);
    bus_wr(5'd24, 32'hFFFF_FFFF);
    bus_rd(5'd24, rd);
    chk("rd_en", rd, 32'h00FF_FFFF);
    stb = 1'b1; rw = 1'b0; addr = 5'd7;
    tick();
    chk("stb_hold_ack1", 32'(ack), 32'd1);
    tick();
    chk("stb_hold_ack2", 32'(ack), 32'd1);
    chk("stb_hold_dout", dout, 32'hDEAD_BEEF);
    stb = 1'b0;

    // simultaneous set and clear: set wins
    bus_wr(5'd24, 32'h0);
    cpu_int[2] = 1'b1;
    tick(); cpu_int = '0;
    tick();
    cpu_int[2] = 1'b1;
    bus_wr(5'd25, 32'h4);
    cpu_int = '0;
    bus_rd(5'd25, rd);
    chk("setclr_pend", rd, 32'h4);
    bus_wr(5'd25, 32'h4);
    bus_rd(5'd25, rd);
    chk("w1c_pend", rd, 32'h0);

    // reset in the middle of a request
    bus_wr(5'd24, 32'h30);
    cpu_int = 24'h30;
    tick(); cpu_int = '0;
    tick(); tick();
    chk("rstmid_req", 32'(intrq), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_async", 32'(intrq), 32'd0);
    tick();
    reset = 1'b1;
    repeat (6) tick();
    chk("rstmid_noreq", 32'(intrq), 32'd0);
    bus_rd(5'd25, rd);
    chk("rstmid_pend", rd, 32'd0);

    // randomized phase against the pending/priority model
    pend_m = '0;
    en_m = '0;
    for (int i = 0; i < 24; i++) tbl_m[i] = '0;
    for (int it = 0; it < 24; it++) begin
      idx = $urandom_range(23, 1);
      tbl_m[idx] = $urandom;
      bus_wr(5'(idx), tbl_m[idx]);
      if ($urandom_range(2, 0) == 0) begin
        en_m = 24'($urandom) & 24'hFFFFFE;
        bus_wr(5'd24, 32'(en_m));
      end
      serve();
      m = '0;
      for (int b = 0; b <= int'($urandom_range(2, 0)); b++) m[$urandom_range(23, 1)] = 1'b1;
      if ($urandom_range(1, 0) == 1) ext_irq = m; else cpu_int = m;
      tick();
      cpu_int = '0; ext_irq = '0;
      pend_m = pend_m | m;
      serve();
      tick(); tick(); tick();
      chk("rnd_idle", 32'(intrq), 32'd0);
      bus_rd(5'd25, rd);
      chk("rnd_pend", rd, 32'(pend_m));
      if ($urandom_range(1, 0) == 1) begin
        m = 24'($urandom);
        bus_wr(5'd25, 32'(m));
        pend_m = pend_m & ~m;
      end
    end
    bus_rd(5'd24, rd);
    chk("rnd_en", rd, 32'({en_m[23:1], 1'b1}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
